// File: rtl/effects_pkg.sv
// Shared definitions for the effects block sequencers.
// State encodings and gain format used by the delay line controller.
package effects_pkg;

    // Controller states: RAM sweep, wait for sample, read latency, mix, write-back
    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_MIX,
        S_WRITE
    } state_t;

    // Gains are unsigned 4-bit values scaled by 1/16
    localparam int GAIN_W     = 4;
    localparam int GAIN_SHIFT = 4;

endpackage

// File: rtl/delay_line_ctrl_sat_mac.sv
// Saturating multiply-accumulate: dry + ((wet * gain) >>> 4).
// Shared by the output mix path and the feedback write-back path.
module sat_mac
    import effects_pkg::*;
#(
    parameter int dat_width = 8
) (
    input  logic signed [dat_width-1:0] i_dry,
    input  logic signed [dat_width-1:0] i_wet,
    input  logic        [GAIN_W-1:0]    i_gain,
    output logic signed [dat_width-1:0] o_res
);

    localparam int PW = dat_width + GAIN_W + 1;
    localparam int SW = dat_width + 2;

    localparam logic signed [SW-1:0] MAXV = SW'((1 << (dat_width - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] w_wet_x;
    logic signed [PW-1:0] w_gain_x;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic signed [SW-1:0] w_sum;

    // Gain is zero-extended so it always acts as a positive multiplier
    assign w_wet_x  = PW'(i_wet);
    assign w_gain_x = PW'({1'b0, i_gain});
    assign w_prod   = w_wet_x * w_gain_x;
    assign w_scaled = w_prod >>> GAIN_SHIFT;
    assign w_sum    = SW'(i_dry) + SW'(w_scaled);

    // Clamp the widened sum back into the sample range
    always_comb begin
        o_res = w_sum[dat_width-1:0];
        if (w_sum > MAXV) begin
            o_res = {1'b0, {(dat_width - 1){1'b1}}};
        end else if (w_sum < MINV) begin
            o_res = {1'b1, {(dat_width - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular delay line sequencer for the echo effect sample RAM.
// Port A writes (sweep and write-back), port B reads the delayed tap.
module delay_line_ctrl
    import effects_pkg::*;
#(
    parameter int adr_width = 13,
    parameter int dat_width = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic        [adr_width-1:0] delay,
    input  logic        [GAIN_W-1:0]    mix_gain,
    input  logic        [GAIN_W-1:0]    fb_gain,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [dat_width-1:0] in_sample,
    output logic                        out_valid,
    output logic signed [dat_width-1:0] out_sample,
    output logic                        busy,
    output logic                        ram_en_a,
    output logic                        ram_we_a,
    output logic        [adr_width-1:0] ram_adr_a,
    output logic signed [dat_width-1:0] ram_dat_a,
    output logic                        ram_en_b,
    output logic        [adr_width-1:0] ram_adr_b,
    input  logic signed [dat_width-1:0] ram_dat_b
);

    localparam logic [adr_width-1:0] LAST_ADR = {adr_width{1'b1}};

    state_t r_state;
    state_t w_state_nxt;
    state_t w_st_eff;

    logic        [adr_width-1:0] r_clr_cnt;
    logic        [adr_width-1:0] r_wr_ptr;
    logic        [adr_width-1:0] r_d;
    logic signed [dat_width-1:0] r_dry;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic signed [dat_width-1:0] r_out_sample;
    logic                        r_busy;
    logic                        r_en_a;
    logic                        r_we_a;
    logic        [adr_width-1:0] r_adr_a;
    logic signed [dat_width-1:0] r_dat_a;
    logic                        r_en_b;
    logic        [adr_width-1:0] r_adr_b;

    logic        [adr_width-1:0] w_clr_cnt_nxt;
    logic        [adr_width-1:0] w_cnt_eff;
    logic        [adr_width-1:0] w_wr_ptr_nxt;
    logic        [adr_width-1:0] w_d_nxt;
    logic signed [dat_width-1:0] w_dry_nxt;
    logic                        w_in_ready_nxt;
    logic                        w_out_valid_nxt;
    logic signed [dat_width-1:0] w_out_sample_nxt;
    logic                        w_busy_nxt;
    logic                        w_en_a_nxt;
    logic                        w_we_a_nxt;
    logic        [adr_width-1:0] w_adr_a_nxt;
    logic signed [dat_width-1:0] w_dat_a_nxt;
    logic                        w_en_b_nxt;
    logic        [adr_width-1:0] w_adr_b_nxt;

    logic                        w_xfer;
    logic signed [dat_width-1:0] w_wet;
    logic signed [dat_width-1:0] w_mix;
    logic signed [dat_width-1:0] w_fb;

    // A zero delay would read the slot about to be written, so force bypass
    assign w_wet = (r_d == '0) ? '0 : ram_dat_b;

    sat_mac #(
        .dat_width(dat_width)
    ) u_mix (
        .i_dry (r_dry),
        .i_wet (w_wet),
        .i_gain(mix_gain),
        .o_res (w_mix)
    );

    sat_mac #(
        .dat_width(dat_width)
    ) u_fb (
        .i_dry (r_dry),
        .i_wet (w_wet),
        .i_gain(fb_gain),
        .o_res (w_fb)
    );

    // A clear pulse overrides whatever is in flight and restarts the sweep
    assign w_st_eff  = clear ? S_CLEAR : r_state;
    assign w_cnt_eff = clear ? '0 : r_clr_cnt;
    assign w_xfer    = in_valid && r_in_ready && !clear;

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_d_nxt          = r_d;
        w_dry_nxt        = r_dry;
        w_in_ready_nxt   = 1'b0;
        w_out_valid_nxt  = 1'b0;
        w_out_sample_nxt = r_out_sample;
        w_busy_nxt       = 1'b0;
        w_en_a_nxt       = 1'b0;
        w_we_a_nxt       = 1'b0;
        w_adr_a_nxt      = r_adr_a;
        w_dat_a_nxt      = r_dat_a;
        w_en_b_nxt       = 1'b0;
        w_adr_b_nxt      = r_adr_b;

        unique case (w_st_eff)
            S_CLEAR: begin
                w_busy_nxt   = 1'b1;
                w_en_a_nxt   = 1'b1;
                w_we_a_nxt   = 1'b1;
                w_adr_a_nxt  = w_cnt_eff;
                w_dat_a_nxt  = '0;
                w_wr_ptr_nxt = '0;
                if (w_cnt_eff == LAST_ADR) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_cnt_nxt = w_cnt_eff + 1'b1;
                    w_state_nxt   = S_CLEAR;
                end
            end
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (w_xfer) begin
                    w_in_ready_nxt = 1'b0;
                    w_dry_nxt      = in_sample;
                    w_d_nxt        = delay;
                    w_en_b_nxt     = 1'b1;
                    w_adr_b_nxt    = r_wr_ptr - delay;
                    w_state_nxt    = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_MIX;
            end
            S_MIX: begin
                w_out_sample_nxt = w_mix;
                w_en_a_nxt       = 1'b1;
                w_we_a_nxt       = 1'b1;
                w_adr_a_nxt      = r_wr_ptr;
                w_dat_a_nxt      = w_fb;
                w_state_nxt      = S_WRITE;
            end
            S_WRITE: begin
                w_out_valid_nxt = 1'b1;
                w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
                w_in_ready_nxt  = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_clr_cnt_nxt = '0;
                w_state_nxt   = S_CLEAR;
            end
        endcase
    end

    // State register; reset starts a full RAM sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_d          <= '0;
            r_dry        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_busy       <= 1'b1;
            r_en_a       <= 1'b0;
            r_we_a       <= 1'b0;
            r_adr_a      <= '0;
            r_dat_a      <= '0;
            r_en_b       <= 1'b0;
            r_adr_b      <= '0;
        end else begin
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_d          <= w_d_nxt;
            r_dry        <= w_dry_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_sample <= w_out_sample_nxt;
            r_busy       <= w_busy_nxt;
            r_en_a       <= w_en_a_nxt;
            r_we_a       <= w_we_a_nxt;
            r_adr_a      <= w_adr_a_nxt;
            r_dat_a      <= w_dat_a_nxt;
            r_en_b       <= w_en_b_nxt;
            r_adr_b      <= w_adr_b_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign busy       = r_busy;
    assign ram_en_a   = r_en_a;
    assign ram_we_a   = r_we_a;
    assign ram_adr_a  = r_adr_a;
    assign ram_dat_a  = r_dat_a;
    assign ram_en_b   = r_en_b;
    assign ram_adr_b  = r_adr_b;

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequencer that drives the effects dual-port sample RAM (write port A, read port B) as a circular delay line for the echo/delay effect.
- Per accepted input sample:
  - reads the delayed sample through port B;
  - produces a dry/wet mixed output;
  - writes input plus feedback back through port A.
- Sits between the audio sample stream and the RAM instance inside wb_effects.
- Clears the RAM after reset or on request so stale content never echoes.

Parameters:
- adr_width, 13, RAM address width; depth = 2^adr_width samples.
- dat_width, 8, sample width; signed two's complement.

Ports:
- clk  in  1  system clock; single clock domain; drives both RAM port clocks.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  one-cycle pulse; starts a RAM zero sweep.
- delay  in  adr_width  delay in samples; sampled at input handshake.
- mix_gain  in  4  wet level in output, gain/16.
- fb_gain  in  4  feedback level written back, gain/16.
- in_valid  in  1  input sample strobe.
- in_ready  out  1  controller can accept a sample.
- in_sample  in  dat_width  dry input sample.
- out_valid  out  1  one-cycle pulse; out_sample is valid.
- out_sample  out  dat_width  mixed output sample.
- busy  out  1  high during clear sweep.
- ram_en_a  out  1  RAM port A enable.
- ram_we_a  out  1  RAM port A write enable.
- ram_adr_a  out  adr_width  RAM port A address.
- ram_dat_a  out  dat_width  RAM port A write data.
- ram_en_b  out  1  RAM port B enable.
- ram_adr_b  out  adr_width  RAM port B address.
- ram_dat_b  in  dat_width  RAM port B read data; valid 1 cycle after the enabled edge.

Behaviour:
- Reset, asynchronous:
  - All outputs go to 0: in_ready, out_valid, out_sample, all ram_* outputs.
  - Internal wr_ptr goes to 0.
  - State goes to CLEAR and busy goes to 1 (busy is asserted during reset).
- All outputs are registered. in_ready = (state==IDLE).
- CLEAR state:
  - Each cycle: ram_en_a=1, ram_we_a=1, ram_dat_a=0, ram_adr_a = clr_cnt.
  - clr_cnt counts 0..depth-1; after the last address go to IDLE and busy=0.
  - Duration is exactly depth cycles. in_valid is ignored. After the sweep wr_ptr=0.
- clear pulse: honoured in any state. Abandons any in-flight sample (no out_valid) and restarts CLEAR from address 0.
- Handshake: transfer when in_valid && in_ready. in_valid while not ready is ignored; there is no buffering.
- IDLE, on transfer:
  - latch dry = in_sample;
  - latch d = delay;
  - ram_en_b=1, ram_adr_b = (wr_ptr - d) mod depth;
  - go to READ.
- READ: ram_en_b=0; wait one cycle for RAM read latency; go to MIX.
- MIX:
  - wet = (d==0) ? 0 : ram_dat_b.
  - out_sample = sat(dry + ((wet*mix_gain) >>> 4)).
  - Drive port A: ram_en_a=1, ram_we_a=1, ram_adr_a=wr_ptr, ram_dat_a = sat(dry + ((wet*fb_gain) >>> 4)).
  - Go to WRITE.
- WRITE:
  - ram_en_a=0, ram_we_a=0;
  - out_valid=1 for one cycle;
  - wr_ptr = wr_ptr+1 (wraps depth-1 -> 0);
  - go to IDLE.
- Timing:
  - Latency: handshake at edge N gives out_valid high after edge N+3.
  - Throughput: 1 sample per 4 cycles.
- Arithmetic:
  - Gains are unsigned, zero-extended to 5 bits.
  - Product is signed, dat_width+5 bits; arithmetic shift right 4.
  - Sum is computed at dat_width+2 bits, then saturated to [-2^(dat_width-1), 2^(dat_width-1)-1].
- Edge cases:
  - delay=0 means pure bypass: out_sample = dry, and the written value = dry.
  - delay=depth-1 reads the oldest entry.
  - delay change takes effect at the next handshake.
- Port A is never driven with we_a=0 and en_a=1, so the RAM's port A read path is unused.

Decomposition:
- Shared package effects_pkg holds:
  - state encodings S_CLEAR, S_IDLE, S_READ, S_MIX, S_WRITE;
  - GAIN_W=4 and GAIN_SHIFT=4.
- One natural sub-module, sat_mac: combinational dry + (wet*gain)>>>4 with saturation. It is instantiated twice (mix path and feedback path).

Test Plan:
- Bench uses adr_width=4, dat_width=8.
- Reset release: busy=1, then 16 cycles of port A writes of 0 at addresses 0..15, then busy=0 and in_ready=1; no out_valid during the sweep.
- delay=0, send 50 -> out_sample=50 three cycles after handshake; RAM[0]=50; wr_ptr becomes 1.
- delay=3, mix_gain=8, fb_gain=0, send 64,0,0,0 -> 4th output = 0 + (64*8)>>>4 = 32; RAM holds 64,0,0,0.
- Saturation: delay=1, mix_gain=15, RAM preloaded 127, send 120 -> out_sample=127. Send -128 against stored -128 -> out_sample=-128.
- Wrap: 20 samples with delay=15 -> wr_ptr wraps 15->0; sample k reads address (k-15) mod 16.
- clear pulse asserted in READ -> no out_valid, full 16-cycle sweep, in_ready low throughout. Reset asserted mid-MIX -> outputs 0 immediately (asynchronous).
